// File: rtl/cacheline_responder.sv
// rtl/cacheline_responder.sv - 256-bit cache line to 4x64-bit memory burst responder.
// Optional one-entry read line buffer: CACHELINE_RESPONDER_LINE_BUFFER_EN.
module cacheline_responder #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        line_addr,
    input  logic [LINE_W-1:0]  line_wdata,
    input  logic               line_read,
    input  logic               line_write,
    output logic [LINE_W-1:0]  line_rdata,
    output logic               line_resp,
    output logic [31:0]        pmem_address,
    output logic               pmem_read,
    output logic               pmem_write,
    output logic [BURST_W-1:0] pmem_wdata,
    input  logic [BURST_W-1:0] pmem_rdata,
    input  logic               pmem_resp
);

    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   beat_q;
    logic [31:0]        addr_q;
    logic [LINE_W-1:0]  wline_q;
    logic [LINE_W-1:0]  rline_q;
    logic [LINE_W-1:0]  rline_d;
    logic [LINE_W-1:0]  rdata_q;
    logic               rd_q;
    logic               wr_q;
    logic               resp_q;
    logic [31:0]        aligned_addr;
    logic               buf_hit;

`ifdef CACHELINE_RESPONDER_LINE_BUFFER_EN
    logic               buf_valid_q;
    logic [31:0]        buf_tag_q;
    logic [LINE_W-1:0]  buf_data_q;

    assign buf_hit = buf_valid_q && (buf_tag_q == aligned_addr);
`else
    assign buf_hit = 1'b0;
`endif

    assign aligned_addr = line_addr & ~32'h1F;

    // Current beat merged into the partially assembled read line.
    always_comb begin
        rline_d = rline_q;
        for (int b = 0; b < BEATS; b++) begin
            if (beat_q == CNT_W'(b)) begin
                rline_d[b*BURST_W +: BURST_W] = pmem_rdata;
            end
        end
    end

    always_comb begin
        pmem_wdata = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (wr_q && beat_q == CNT_W'(b)) begin
                pmem_wdata = wline_q[b*BURST_W +: BURST_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
            rdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            resp_q  <= 1'b0;
`ifdef CACHELINE_RESPONDER_LINE_BUFFER_EN
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (line_read) begin
                        addr_q <= aligned_addr;
                        beat_q <= '0;
                        if (buf_hit) begin
`ifdef CACHELINE_RESPONDER_LINE_BUFFER_EN
                            rdata_q <= buf_data_q;
`endif
                            resp_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            rd_q    <= 1'b1;
                            state_q <= RD_BURST;
                        end
                    end else if (line_write) begin
                        addr_q  <= aligned_addr;
                        wline_q <= line_wdata;
                        beat_q  <= '0;
                        wr_q    <= 1'b1;
                        state_q <= WR_BURST;
                    end
                end
                RD_BURST: begin
                    if (pmem_resp) begin
                        rline_q <= rline_d;
                        beat_q  <= beat_q + 1'b1;
                        if (beat_q == LAST_BEAT) begin
                            rdata_q <= rline_d;
                            rd_q    <= 1'b0;
                            resp_q  <= 1'b1;
                            state_q <= DONE;
`ifdef CACHELINE_RESPONDER_LINE_BUFFER_EN
                            buf_valid_q <= 1'b1;
                            buf_tag_q   <= addr_q;
                            buf_data_q  <= rline_d;
`endif
                        end
                    end
                end
                WR_BURST: begin
                    if (pmem_resp) begin
                        beat_q <= beat_q + 1'b1;
                        if (beat_q == LAST_BEAT) begin
                            wr_q    <= 1'b0;
                            resp_q  <= 1'b1;
                            state_q <= DONE;
`ifdef CACHELINE_RESPONDER_LINE_BUFFER_EN
                            // Tag match or not, the buffer ends up holding the written line.
                            buf_valid_q <= 1'b1;
                            buf_tag_q   <= addr_q;
                            buf_data_q  <= wline_q;
`endif
                        end
                    end
                end
                DONE: begin
                    resp_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign line_rdata   = rdata_q;
    assign line_resp    = resp_q;
    assign pmem_address = addr_q;
    assign pmem_read    = rd_q;
    assign pmem_write   = wr_q;

endmodule

// File: tb/tb_cacheline_responder.sv
// tb/tb_cacheline_responder.sv - directed self-checking bench for cacheline_responder.
module tb_cacheline_responder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  line_addr;
    logic [255:0] line_wdata;
    logic         line_read;
    logic         line_write;
    logic [255:0] line_rdata;
    logic         line_resp;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [63:0]  pmem_wdata;
    logic [63:0]  pmem_rdata;
    logic         pmem_resp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cacheline_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .line_addr    (line_addr),
        .line_wdata   (line_wdata),
        .line_read    (line_read),
        .line_write   (line_write),
        .line_rdata   (line_rdata),
        .line_resp    (line_resp),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Caller is at the negedge before the sampling edge; line_read is raised here.
    task automatic rd_line(input string tag, input logic [31:0] a, input logic [255:0] line);
        line_read = 1'b1;
        line_addr = a;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check_eq({tag, "_rd"}, 256'(pmem_read), 256'd1);
            check_eq({tag, "_nowr"}, 256'(pmem_write), 256'd0);
            check_eq({tag, "_addr"}, 256'(pmem_address), 256'(a & ~32'h1F));
            check_eq({tag, "_noresp"}, 256'(line_resp), 256'd0);
            pmem_rdata = line[(c-1)*64 +: 64];
            pmem_resp  = 1'b1;
        end
        tick();
        check_eq({tag, "_resp"}, 256'(line_resp), 256'd1);
        check_eq({tag, "_rd_low"}, 256'(pmem_read), 256'd0);
        check_eq({tag, "_data"}, line_rdata, line);
        line_read  = 1'b0;
        line_write = 1'b0;
        pmem_resp  = 1'b0;
        tick();
        check_eq({tag, "_resp_pulse"}, 256'(line_resp), 256'd0);
        check_eq({tag, "_data_hold"}, line_rdata, line);
    endtask

    logic [255:0] l1, lw, l3, l6, l4, l4w;
    logic [63:0]  expw [5];
    logic         rp   [5];
    int           accepted;

    initial begin
        rst_n = 1'b0; line_addr = '0; line_wdata = '0; line_read = 1'b0; line_write = 1'b0;
        pmem_rdata = '0; pmem_resp = 1'b0;
        l1  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        lw  = {64'hD, 64'hC, 64'hB, 64'hA};
        l3  = {64'hC3C3_0003, 64'hC3C3_0002, 64'hC3C3_0001, 64'hC3C3_0000};
        l6  = {64'h6666_0003, 64'h6666_0002, 64'h6666_0001, 64'h6666_0000};
        l4  = {64'h4040_0003, 64'h4040_0002, 64'h4040_0001, 64'h4040_0000};
        l4w = {64'hBEEF_0003, 64'hBEEF_0002, 64'hBEEF_0001, 64'hBEEF_0000};

        tick(); tick();
        check_eq("rst_resp", 256'(line_resp), 256'd0);
        check_eq("rst_rdata", line_rdata, 256'd0);
        check_eq("rst_rd", 256'(pmem_read), 256'd0);
        check_eq("rst_wr", 256'(pmem_write), 256'd0);
        check_eq("rst_addr", 256'(pmem_address), 256'd0);
        check_eq("rst_wdata", 256'(pmem_wdata), 256'd0);
        rst_n = 1'b1;
        tick();

        rd_line("read1004", 32'h0000_1004, l1);

        expw = '{64'hA, 64'hB, 64'hB, 64'hC, 64'hD};
        rp   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        accepted = 0;
        line_write = 1'b1; line_addr = 32'h0000_2000; line_wdata = lw;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq("wr_active", 256'(pmem_write), 256'd1);
            check_eq("wr_addr", 256'(pmem_address), 256'h2000);
            check_eq("wr_beat", 256'(pmem_wdata), 256'(expw[c]));
            check_eq("wr_noresp", 256'(line_resp), 256'd0);
            pmem_resp = rp[c];
            if (rp[c] && pmem_write) accepted++;
        end
        tick();
        check_eq("wr_resp", 256'(line_resp), 256'd1);
        check_eq("wr_low", 256'(pmem_write), 256'd0);
        check_eq("wr_beats", 256'(accepted), 256'd4);
        check_eq("wr_rdata_kept", line_rdata, l1);
        line_write = 1'b0; pmem_resp = 1'b0;
        tick();
        check_eq("wr_resp_pulse", 256'(line_resp), 256'd0);

        line_write = 1'b1; line_wdata = lw;
        rd_line("rdwr3000", 32'h0000_3000, l3);
        tick();
        check_eq("rdwr_no_late_wr", 256'(pmem_write), 256'd0);

        line_read = 1'b1; line_addr = 32'h0000_5004;
        for (int c = 0; c < 3; c++) begin
            tick();
            pmem_rdata = 64'hDEAD_0000 + 64'(c);
            pmem_resp  = 1'b1;
        end
        tick();
        check_eq("abort_rd_mid", 256'(pmem_read), 256'd1);
        pmem_resp = 1'b0; line_read = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_rd", 256'(pmem_read), 256'd0);
        check_eq("abort_wr", 256'(pmem_write), 256'd0);
        check_eq("abort_resp", 256'(line_resp), 256'd0);
        check_eq("abort_addr", 256'(pmem_address), 256'd0);
        check_eq("abort_rdata", line_rdata, 256'd0);
        check_eq("abort_wdata", 256'(pmem_wdata), 256'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq("abort_no_resp", 256'(line_resp), 256'd0);
            check_eq("abort_idle", 256'(pmem_read), 256'd0);
        end
        rd_line("after_rst", 32'h0000_6000, l6);

`ifdef CACHELINE_RESPONDER_LINE_BUFFER_EN
        rd_line("buf_fill", 32'h0000_4000, l4);
        line_read = 1'b1; line_addr = 32'h0000_4010;
        tick();
        check_eq("hit_resp", 256'(line_resp), 256'd1);
        check_eq("hit_no_rd", 256'(pmem_read), 256'd0);
        check_eq("hit_data", line_rdata, l4);
        line_read = 1'b0;
        tick();
        check_eq("hit_pulse", 256'(line_resp), 256'd0);

        line_write = 1'b1; line_addr = 32'h0000_4000; line_wdata = l4w;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_eq("wt_active", 256'(pmem_write), 256'd1);
            check_eq("wt_beat", 256'(pmem_wdata), 256'(l4w[c*64 +: 64]));
            pmem_resp = 1'b1;
        end
        tick();
        check_eq("wt_resp", 256'(line_resp), 256'd1);
        line_write = 1'b0; pmem_resp = 1'b0;
        tick();
        line_read = 1'b1; line_addr = 32'h0000_4000;
        tick();
        check_eq("wt_hit_resp", 256'(line_resp), 256'd1);
        check_eq("wt_hit_no_rd", 256'(pmem_read), 256'd0);
        check_eq("wt_hit_data", line_rdata, l4w);
        line_read = 1'b0;
        tick();
`else
        rd_line("reread1000", 32'h0000_1000, l1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
